// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM encoding and
// small opcode-decode helpers used by the unit, the controller and the execute mux.
package mdu_pkg;

    localparam int MDU_ITERS = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_code);
        return ~op_code[0];
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate; gives magnitudes at accept and
// restores result signs once the unsigned iteration has finished.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle radix-2 multiply/divide unit (shift-add multiply, restoring divide)
// with a start/busy/done handshake and hi/lo result registers.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_r, state_s;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   opa_r, opb_r, orig_a_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic               neg_res_r, neg_rem_r;
    logic               busy_r, done_r, busy_s, done_s;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               accept_s, last_s, a_neg_s, b_neg_s, div_zero_s, div_ok_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s, quo_fix_s, rem_fix_s, new_rem_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_trial_s;

    assign accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s     = (cnt_r == CW'(WIDTH - 1));
    assign a_neg_s    = op_is_signed(op) & operand_a[WIDTH-1];
    assign b_neg_s    = op_is_signed(op) & operand_b[WIDTH-1];
    assign div_zero_s = (opb_r == {WIDTH{1'b0}});

    mdu_signfix #(.W(WIDTH))   u_abs_a    (.value(operand_a), .negate(a_neg_s), .result(abs_a_s));
    mdu_signfix #(.W(WIDTH))   u_abs_b    (.value(operand_b), .negate(b_neg_s), .result(abs_b_s));
    mdu_signfix #(.W(2*WIDTH)) u_fix_prod (.value(acc_r), .negate(neg_res_r), .result(prod_fix_s));
    mdu_signfix #(.W(WIDTH))   u_fix_quo  (.value(acc_r[WIDTH-1:0]), .negate(neg_res_r), .result(quo_fix_s));
    mdu_signfix #(.W(WIDTH))   u_fix_rem  (.value(acc_r[2*WIDTH-1:WIDTH]), .negate(neg_rem_r), .result(rem_fix_s));

    // Multiply step: add multiplicand into the upper half when the current multiplier bit is set.
    assign mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                     + (opb_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});

    // Divide step: remainder lives in acc upper half, quotient bits shift into the lower half.
    assign div_shift_s = {acc_r[2*WIDTH-1:WIDTH], opa_r[WIDTH-1]};
    assign div_trial_s = div_shift_s - {1'b0, opb_r};
    assign div_ok_s    = div_shift_s[WIDTH] | ~div_trial_s[WIDTH];
    assign new_rem_s   = div_ok_s ? div_trial_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];

    // Sign correction and divide-by-zero substitution applied in FIX.
    always_comb begin
        fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_fix_s[WIDTH-1:0];
        if (op_is_div(op_r)) begin
            if (div_zero_s) begin
                fix_hi_s = orig_a_r;
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_hi_s = rem_fix_s;
                fix_lo_s = quo_fix_s;
            end
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = start ? ST_CALC : ST_IDLE;
            ST_CALC: state_s = last_s ? ST_FIX : ST_CALC;
            ST_FIX:  state_s = ST_DONE;
            ST_DONE: state_s = start ? ST_CALC : ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state so busy/done can be registered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_CALC: busy_s = 1'b1;
            ST_FIX:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Operand capture, iteration datapath and hi/lo result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r      <= 2'b00;
            opa_r     <= {WIDTH{1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            orig_a_r  <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CW{1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            op_r      <= op;
            opa_r     <= abs_a_s;
            opb_r     <= abs_b_s;
            orig_a_r  <= operand_a;
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CW{1'b0}};
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s & op_is_div(op);
        end else begin
            case (state_r)
                ST_CALC: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (op_is_div(op_r)) begin
                        acc_r <= {new_rem_s, acc_r[WIDTH-2:0], div_ok_s};
                        opa_r <= {opa_r[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                        opb_r <= {1'b0, opb_r[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases, randomized operations,
// busy-start rejection, back-to-back issue and mid-operation reset.
module tb_mul_div_unit;

    logic        clk, reset, start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];
    int          cyc_q[$];
    logic [63:0] last_exp = 64'd0;
    logic [63:0] mon_e;
    int          mon_c;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, result as {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin p = sa * sb; return p; end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h00000000; corners[1] = 32'h00000001; corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000; corners[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation at cycle %0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = cyc_q.pop_front();
                check("hi", {32'd0, hi}, {32'd0, mon_e[63:32]});
                check("lo", {32'd0, lo}, {32'd0, mon_e[31:0]});
                check("latency", 64'(cyc - mon_c), 64'd33);
                last_exp = mon_e;
            end
        end
    end

    // Call at a negedge while the unit is idle or in its done cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        exp_q.push_back(ref_model(o, a, b));
        cyc_q.push_back(cyc);
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = 32'd0; operand_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(2'b00, 32'hFFFFFFFD, 32'd7);           wait_done(); @(negedge clk);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);    wait_done(); @(negedge clk);
        issue(2'b10, 32'hFFFFFFF9, 32'd2);           wait_done(); @(negedge clk);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);    wait_done(); @(negedge clk);
        issue(2'b11, 32'h00000064, 32'd0);           wait_done(); @(negedge clk);

        // Start while busy must be ignored; results must hold meanwhile.
        issue(2'b11, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        check("hold_hilo", {hi, lo}, last_exp);
        start = 1'b1; op = 2'b00; operand_a = 32'h12345678; operand_b = 32'h0000ABCD;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_ignored_start", {63'd0, busy}, 64'd1);
        wait_done();

        // Back-to-back: next request in the done cycle.
        issue(2'b01, $urandom, $urandom);
        wait_done();
        issue(2'b10, pick_operand(), pick_operand());
        wait_done();

        for (int i = 0; i < 25; i++) begin
            issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
            wait_done();
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        @(negedge clk);

        // Reset mid-operation aborts it without a done pulse.
        issue(2'b01, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        cyc_q.delete();
        last_exp = 64'd0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        base = done_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - base), 64'd0);

        // Reset and start on the same edge: request dropped.
        reset = 1'b1; start = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("reset_start_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("reset_start_idle", {63'd0, busy}, 64'd0);

        issue(2'b00, 32'h7FFFFFFF, 32'h80000000);
        wait_done();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
